// File: rtl/multdiv_unit_pkg.sv
// Shared decode constants, exception codes and FSM encoding for the multiply/divide unit.
package multdiv_unit_pkg;
  localparam logic [4:0]  OPC_ALU      = 5'b00000;
  localparam logic [4:0]  ALUOP_MUL    = 5'b00110;
  localparam logic [4:0]  ALUOP_DIV    = 5'b00111;
  localparam logic [31:0] EXC_MUL_OVF  = 32'd4;
  localparam logic [31:0] EXC_DIV_ZERO = 32'd5;
  localparam logic [4:0]  REG_EXC      = 5'd30;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;
endpackage

// File: rtl/multdiv_datapath.sv
// Shared shift register for radix-2 Booth multiply and restoring divide; one step per i_step.
// Next-step values are exposed so the owner can register the final result on the last step.
module multdiv_datapath #(
  parameter int WIDTH = 32
) (
  input  logic               i_clock,
  input  logic               i_rst,
  input  logic               i_load,
  input  logic               i_load_div,
  input  logic               i_step,
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  output logic [2*WIDTH-1:0] o_prod_nxt,
  output logic [WIDTH-1:0]   o_quot_nxt
);
  // Multiply layout: {upper[W], multiplier[W], booth_extra}; divide: {remainder[W+1], quotient[W]}.
  logic [2*WIDTH:0] r_acc;
  logic [WIDTH-1:0] r_m;
  logic             r_div;

  logic [WIDTH:0] w_upper;
  logic [WIDTH:0] w_mcand;
  logic [WIDTH:0] w_sum;
  logic [WIDTH:0] w_shift;
  logic [WIDTH:0] w_diff;
  logic [WIDTH:0] w_rem_nxt;

  always_comb begin
    w_upper = {r_acc[2*WIDTH], r_acc[2*WIDTH:WIDTH+1]};
    w_mcand = {r_m[WIDTH-1], r_m};
    case (r_acc[1:0])
      2'b01:   w_sum = w_upper + w_mcand;
      2'b10:   w_sum = w_upper - w_mcand;
      default: w_sum = w_upper;
    endcase
    // The W+1-bit sum keeps its true sign, so the arithmetic shift never wraps.
    o_prod_nxt = {w_sum, r_acc[WIDTH:2]};

    w_shift    = r_acc[2*WIDTH-1:WIDTH-1];
    w_diff     = w_shift - {1'b0, r_m};
    w_rem_nxt  = w_diff[WIDTH] ? w_shift : w_diff;
    o_quot_nxt = {r_acc[WIDTH-2:0], ~w_diff[WIDTH]};
  end

  always_ff @(posedge i_clock or posedge i_rst) begin
    if (i_rst) begin
      r_acc <= '0;
      r_m   <= '0;
      r_div <= 1'b0;
    end else if (i_load) begin
      r_div <= i_load_div;
      r_m   <= i_b;
      r_acc <= i_load_div ? {{(WIDTH+1){1'b0}}, i_a} : {{WIDTH{1'b0}}, i_a, 1'b0};
    end else if (i_step) begin
      r_acc <= r_div ? {w_rem_nxt, o_quot_nxt} : {o_prod_nxt, r_acc[1]};
    end
  end
endmodule

// File: rtl/multdiv_unit.sv
// Iterative signed mul/div for execute: WIDTH+1 cycles start-to-result (div-by-zero: 1 cycle).
// Stalls the front end from the start cycle through the last iteration; result is a one-cycle pulse.
module multdiv_unit
  import multdiv_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [31:0]      executeIR,
  input  logic [WIDTH-1:0] operandA,
  input  logic [WIDTH-1:0] operandB,
  output logic             stall,
  output logic             result_valid,
  output logic [WIDTH-1:0] result,
  output logic [31:0]      result_IR,
  output logic             exception,
  output logic [31:0]      exception_code,
  output logic             busy
);
  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [31:0]     r_ir;
  logic            r_is_div;
  logic            r_neg;
  logic            r_result_valid;
  logic [WIDTH-1:0] r_result;
  logic [31:0]     r_result_ir;
  logic            r_exc;
  logic [31:0]     r_code;

  logic             w_is_mul;
  logic             w_is_div;
  logic             w_start;
  logic [WIDTH-1:0] w_abs_a;
  logic [WIDTH-1:0] w_abs_b;
  logic [2*WIDTH-1:0] w_prod_nxt;
  logic [WIDTH-1:0] w_quot_nxt;
  logic [WIDTH-1:0] w_prod_lo;
  logic             w_ovf;
  logic [WIDTH-1:0] w_quot_signed;

  assign w_is_mul = (executeIR[31:27] == OPC_ALU) && (executeIR[6:2] == ALUOP_MUL);
  assign w_is_div = (executeIR[31:27] == OPC_ALU) && (executeIR[6:2] == ALUOP_DIV);
  assign w_start  = in_valid && (w_is_mul || w_is_div) && (r_state == ST_IDLE);

  assign w_abs_a = operandA[WIDTH-1] ? ('0 - operandA) : operandA;
  assign w_abs_b = operandB[WIDTH-1] ? ('0 - operandB) : operandB;

  assign w_prod_lo     = w_prod_nxt[WIDTH-1:0];
  assign w_ovf         = w_prod_nxt[2*WIDTH-1:WIDTH] != {WIDTH{w_prod_lo[WIDTH-1]}};
  assign w_quot_signed = r_neg ? ('0 - w_quot_nxt) : w_quot_nxt;

  multdiv_datapath #(.WIDTH(WIDTH)) u_datapath (
    .i_clock    (clock),
    .i_rst      (reset),
    .i_load     (w_start),
    .i_load_div (w_is_div),
    .i_step     (r_state == ST_RUN),
    .i_a        (w_is_div ? w_abs_a : operandA),
    .i_b        (w_is_div ? w_abs_b : operandB),
    .o_prod_nxt (w_prod_nxt),
    .o_quot_nxt (w_quot_nxt)
  );

  // Mealy in IDLE so the issuing instruction is held in X on its start cycle.
  assign stall          = w_start || (r_state == ST_RUN);
  assign busy           = r_state != ST_IDLE;
  assign result_valid   = r_result_valid;
  assign result         = r_result;
  assign result_IR      = r_result_ir;
  assign exception      = r_exc;
  assign exception_code = r_code;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state        <= ST_IDLE;
      r_cnt          <= '0;
      r_ir           <= '0;
      r_is_div       <= 1'b0;
      r_neg          <= 1'b0;
      r_result_valid <= 1'b0;
      r_result       <= '0;
      r_result_ir    <= '0;
      r_exc          <= 1'b0;
      r_code         <= '0;
    end else begin
      r_result_valid <= 1'b0;
      r_result       <= '0;
      r_result_ir    <= '0;
      r_exc          <= 1'b0;
      r_code         <= '0;
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_ir     <= executeIR;
            r_is_div <= w_is_div;
            r_neg    <= operandA[WIDTH-1] ^ operandB[WIDTH-1];
            r_cnt    <= '0;
            if (w_is_div && (operandB == '0)) begin
              r_state        <= ST_DONE;
              r_result_valid <= 1'b1;
              r_result_ir    <= executeIR;
              r_exc          <= 1'b1;
              r_code         <= EXC_DIV_ZERO;
            end else begin
              r_state <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          if (r_cnt == LAST) begin
            r_state        <= ST_DONE;
            r_result_valid <= 1'b1;
            r_result_ir    <= r_ir;
            if (r_is_div) begin
              r_result <= w_quot_signed;
            end else begin
              r_result <= w_prod_lo;
              r_exc    <= w_ovf;
              r_code   <= w_ovf ? EXC_MUL_OVF : 32'd0;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_multdiv_unit.sv
// Directed bench for multdiv_unit: a pipeline-like driver holds each instruction in X for its
// expected occupancy, and a cycle-level arithmetic model is compared on every falling edge.
module tb_multdiv_unit;
  logic        clock;
  logic        reset;
  logic        in_valid;
  logic [31:0] executeIR;
  logic [31:0] operandA;
  logic [31:0] operandB;
  logic        stall;
  logic        result_valid;
  logic [31:0] result;
  logic [31:0] result_IR;
  logic        exception;
  logic [31:0] exception_code;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;

  logic        chk_en;
  logic        exp_stall, exp_busy, exp_rv, exp_exc;
  logic [31:0] exp_res, exp_ir, exp_code;

  typedef struct {
    logic        vld;
    logic [31:0] ir;
    logic [31:0] a;
    logic [31:0] b;
    logic        lit;
    logic [31:0] lres;
    logic        lexc;
    logic [31:0] lcode;
    int          rst_at;
  } vec_t;

  vec_t prog[$];

  multdiv_unit #(.WIDTH(32)) dut (
    .clock          (clock),
    .reset          (reset),
    .in_valid       (in_valid),
    .executeIR      (executeIR),
    .operandA       (operandA),
    .operandB       (operandB),
    .stall          (stall),
    .result_valid   (result_valid),
    .result         (result),
    .result_IR      (result_IR),
    .exception      (exception),
    .exception_code (exception_code),
    .busy           (busy)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h, expected %08h at t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (chk_en) begin
      chk("stall",          32'(stall),        32'(exp_stall));
      chk("busy",           32'(busy),         32'(exp_busy));
      chk("result_valid",   32'(result_valid), 32'(exp_rv));
      chk("result",         result,            exp_res);
      chk("result_IR",      result_IR,         exp_ir);
      chk("exception",      32'(exception),    32'(exp_exc));
      chk("exception_code", exception_code,    exp_code);
    end
  end

  function automatic logic [31:0] mk_ir(input logic [4:0] opc, input logic [4:0] rd, input logic [4:0] aluop);
    return {opc, rd, 10'h2A5, rd, aluop, 2'b01};
  endfunction

  // Arithmetic reference: 64-bit signed product, or truncating signed division.
  task automatic model(input logic is_div, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output logic exc, output logic [31:0] code);
    longint p;
    int     sa;
    int     sb;
    if (!is_div) begin
      p    = longint'($signed(a)) * longint'($signed(b));
      res  = p[31:0];
      exc  = (p != longint'($signed(res)));
      code = exc ? 32'd4 : 32'd0;
    end else if (b == 32'd0) begin
      res  = 32'd0;
      exc  = 1'b1;
      code = 32'd5;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      res  = 32'h8000_0000;
      exc  = 1'b0;
      code = 32'd0;
    end else begin
      sa   = a;
      sb   = b;
      res  = sa / sb;
      exc  = 1'b0;
      code = 32'd0;
    end
  endtask

  task automatic add_v(input logic vld, input logic [4:0] opc, input logic [4:0] rd, input logic [4:0] aluop,
                       input logic [31:0] a, input logic [31:0] b, input logic lit,
                       input logic [31:0] lres, input logic lexc, input logic [31:0] lcode, input int rst_at);
    vec_t v;
    v.vld = vld; v.ir = mk_ir(opc, rd, aluop); v.a = a; v.b = b;
    v.lit = lit; v.lres = lres; v.lexc = lexc; v.lcode = lcode; v.rst_at = rst_at;
    prog.push_back(v);
  endtask

  task automatic run_vec(input vec_t v);
    logic        is_mul, is_div, start, dz, mexc;
    logic [31:0] mres, mcode;
    int          d;
    is_mul = (v.ir[31:27] == 5'b00000) && (v.ir[6:2] == 5'b00110);
    is_div = (v.ir[31:27] == 5'b00000) && (v.ir[6:2] == 5'b00111);
    start  = v.vld && (is_mul || is_div);
    dz     = start && is_div && (v.b == 32'd0);
    d      = !start ? 1 : (dz ? 2 : 34);
    model(is_div, v.a, v.b, mres, mexc, mcode);
    for (int c = 0; c < d; c++) begin
      in_valid  = v.vld;
      executeIR = v.ir;
      operandA  = (c == 0) ? v.a : $urandom;
      operandB  = (c == 0) ? v.b : $urandom;
      exp_stall = start && (dz ? (c == 0) : (c <= 32));
      exp_busy  = start && (c >= 1);
      exp_rv    = start && (c == d - 1);
      exp_res   = exp_rv ? mres : 32'd0;
      exp_exc   = exp_rv ? mexc : 1'b0;
      exp_code  = exp_rv ? mcode : 32'd0;
      exp_ir    = exp_rv ? v.ir : 32'd0;
      if (c == v.rst_at) begin
        chk_en = 1'b0;
        #2;
        reset    = 1'b1;
        in_valid = 1'b0;
        #1;
        chk("rst_stall",    32'(stall),        32'd0);
        chk("rst_busy",     32'(busy),         32'd0);
        chk("rst_valid",    32'(result_valid), 32'd0);
        chk("rst_result",   result,            32'd0);
        chk("rst_exc",      32'(exception),    32'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        break;
      end
      chk_en = 1'b1;
      @(negedge clock);
      if (exp_rv && v.lit) begin
        chk("lit_result", result,          v.lres);
        chk("lit_exc",    32'(exception),  32'(v.lexc));
        chk("lit_code",   exception_code,  v.lcode);
      end
      @(posedge clock);
      #1;
    end
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; executeIR = '0; operandA = '0; operandB = '0;
    chk_en = 1'b0; exp_stall = 0; exp_busy = 0; exp_rv = 0; exp_exc = 0;
    exp_res = '0; exp_ir = '0; exp_code = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("reset_stall",  32'(stall),        32'd0);
    chk("reset_busy",   32'(busy),         32'd0);
    chk("reset_valid",  32'(result_valid), 32'd0);
    chk("reset_result", result,            32'd0);
    chk("reset_ir",     result_IR,         32'd0);
    chk("reset_exc",    32'(exception),    32'd0);
    chk("reset_code",   exception_code,    32'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;

    //    vld opc    rd     aluop  A             B             lit res           exc code  rst
    add_v(1, 5'd0, 5'd1,  5'd6, 32'd7,         32'hFFFF_FFFD, 1, 32'hFFFF_FFEB, 0, 32'd0, -1);
    add_v(1, 5'd0, 5'd2,  5'd6, 32'h0001_0000, 32'h0001_0000, 1, 32'h0000_0000, 1, 32'd4, -1);
    add_v(1, 5'd0, 5'd5,  5'd7, 32'hFFFF_FFF9, 32'd2,         1, 32'hFFFF_FFFD, 0, 32'd0, -1);
    add_v(1, 5'd0, 5'd6,  5'd7, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h8000_0000, 0, 32'd0, -1);
    add_v(1, 5'd0, 5'd7,  5'd7, 32'd5,         32'd0,         1, 32'd0,         1, 32'd5, -1);
    add_v(1, 5'd0, 5'd3,  5'd6, 32'd100,       32'hFFFF_FFFB, 1, 32'hFFFF_FE0C, 0, 32'd0, -1);
    add_v(1, 5'd0, 5'd4,  5'd7, 32'd1000,      32'hFFFF_FFF9, 1, 32'hFFFF_FF72, 0, 32'd0, -1);
    add_v(1, 5'd0, 5'd8,  5'd0, 32'd9,         32'd9,         0, 32'd0,         0, 32'd0, -1);
    add_v(1, 5'd5, 5'd9,  5'd6, 32'd9,         32'd9,         0, 32'd0,         0, 32'd0, -1);
    add_v(1, 5'd0, 5'd10, 5'd6, 32'h8000_0000, 32'h8000_0000, 1, 32'd0,         1, 32'd4, -1);
    add_v(1, 5'd0, 5'd11, 5'd6, 32'h8000_0000, 32'd1,         1, 32'h8000_0000, 0, 32'd0, -1);
    add_v(1, 5'd0, 5'd12, 5'd6, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 32'd1,         0, 32'd0, -1);
    add_v(1, 5'd0, 5'd13, 5'd6, 32'h7FFF_FFFF, 32'd2,         1, 32'hFFFF_FFFE, 1, 32'd4, -1);
    add_v(1, 5'd0, 5'd14, 5'd7, 32'h8000_0000, 32'd1,         0, 32'd0,         0, 32'd0, -1);
    add_v(1, 5'd0, 5'd15, 5'd7, 32'd3,         32'd7,         1, 32'd0,         0, 32'd0, -1);
    add_v(1, 5'd0, 5'd16, 5'd7, 32'd7,         32'hFFFF_FFF9, 1, 32'hFFFF_FFFF, 0, 32'd0, -1);
    add_v(1, 5'd0, 5'd17, 5'd7, 32'h8000_0000, 32'h8000_0000, 1, 32'd1,         0, 32'd0, -1);
    add_v(1, 5'd0, 5'd18, 5'd7, 32'hFFFF_FFFF, 32'h8000_0000, 0, 32'd0,         0, 32'd0, -1);
    add_v(1, 5'd0, 5'd19, 5'd7, 32'h7FFF_FFFF, 32'hFFFF_FFFE, 1, 32'hC000_0001, 0, 32'd0, -1);
    add_v(1, 5'd0, 5'd20, 5'd6, 32'd6,         32'd7,         0, 32'd0,         0, 32'd0, 10);
    add_v(0, 5'd0, 5'd21, 5'd6, 32'd6,         32'd7,         0, 32'd0,         0, 32'd0, -1);
    add_v(0, 5'd0, 5'd21, 5'd6, 32'd6,         32'd7,         0, 32'd0,         0, 32'd0, -1);
    add_v(0, 5'd0, 5'd21, 5'd6, 32'd6,         32'd7,         0, 32'd0,         0, 32'd0, -1);
    add_v(1, 5'd0, 5'd22, 5'd6, 32'd6,         32'd7,         1, 32'd42,        0, 32'd0, -1);
    add_v(1, 5'd0, 5'd23, 5'd7, 32'hFFFF_FFFF, 32'd0,         1, 32'd0,         1, 32'd5, -1);

    foreach (prog[i]) run_vec(prog[i]);
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
